// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer: opcode encoding,
// controller states and the 8-bit signed datapath type.
package alu_sequencer_pkg;

  typedef logic signed [7:0] data_t;

  // Compute ops produce a result beat; state ops only touch A/B.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SHL  = 4'b0010;
  localparam logic [3:0] OP_SAR  = 4'b0011;
  localparam logic [3:0] OP_CMP  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_NEG  = 4'b1100;
  localparam logic [3:0] OP_MOVY = 4'b1101;
  localparam logic [3:0] OP_SWAP = 4'b1110;
  localparam logic [3:0] OP_LDA  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    data_t      data;
  } instr_t;

endpackage

// File: rtl/alu_sequencer_alu_core.sv
// Purely combinational 8-bit ALU; all results wrap modulo 256.
module alu_core
  import alu_sequencer_pkg::*;
(
  input  data_t      a,
  input  data_t      b,
  input  logic [3:0] op,
  output data_t      y
);

  // Select the operation; state-op encodings fall through to zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SHL:  y = a <<< 1;
      OP_SAR:  y = a >>> 1;
      OP_CMP:  y = (a == b) ? 8'sh00 : ((a > b) ? 8'sh01 : 8'shFF);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_NEG:  y = -a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction FIFO feeding a three-state controller (IDLE/EXEC/RESP) that
// runs each instruction against registers A/B and presents compute results
// on a valid/ready result port.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [3:0]               instr_op,
  input  logic [7:0]               instr_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_y,
  output logic [7:0]               ALed,
  output logic [7:0]               BLed,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  instr_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  state_e          state_q, state_d;
  instr_t          instr_q, instr_d;
  data_t           a_q, a_d, b_q, b_d, y_q, y_d;
  data_t           alu_y;
  logic            push, pop;

  assign instr_ready = (count_q != FULL_COUNT);
  assign push        = instr_valid && instr_ready;
  assign res_valid   = (state_q == RESP);
  assign res_y       = y_q;
  assign ALed        = a_q;
  assign BLed        = b_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign fifo_count  = count_q;

  alu_core u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (instr_q.op),
    .y  (alu_y)
  );

  // FIFO storage: written on every accepted instruction.
  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and count, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {instr_op, instr_data};
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointers wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: instruction, A, B and result Y.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, which makes the A/B swap atomic.
    if (reset) begin
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else begin
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  // Next-state and datapath control: pop in IDLE, execute, hold the result.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          instr_d = mem_q[rd_ptr_q];
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        case (instr_q.op)
          OP_MOVY: a_d = y_q;
          OP_SWAP: begin
            a_d = b_q;
            b_d = a_q;
          end
          OP_LDA:  a_d = instr_q.data;
          default: begin
            y_d     = alu_y;
            state_d = RESP;
          end
        endcase
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with hand-computed expectations.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [7:0] instr_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_y;
  logic [7:0] ALed;
  logic [7:0] BLed;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_data  (instr_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_y       (res_y),
    .ALed        (ALed),
    .BLed        (BLed),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; an offered instruction is withdrawn once the edge accepts it.
  task automatic step();
    logic accepted;
    accepted = instr_valid && instr_ready;
    @(posedge clk);
    #1;
    if (accepted) instr_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] d);
    instr_op    = op;
    instr_data  = d;
    instr_valid = 1'b1;
    for (int i = 0; i < 40 && instr_valid; i++) step();
    if (instr_valid) begin
      check("push_timeout", 16'(instr_valid), 16'h0);
      instr_valid = 1'b0;
    end
  endtask

  task automatic get_result(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 40 && !res_valid; i++) step();
    if (!res_valid) check({tag, "_timeout"}, 16'(res_valid), 16'h1);
    check(tag, 16'(res_y), 16'(exp));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) step();
    check(tag, 16'(busy), 16'h0);
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_data  = '0;
    res_ready   = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_res_valid", 16'(res_valid), 16'h0);
    check("rst_instr_ready", 16'(instr_ready), 16'h1);
    check("rst_count", 16'(fifo_count), 16'h0);
    check("rst_A", 16'(ALed), 16'h00);
    check("rst_B", 16'(BLed), 16'h00);
    check("rst_Y", 16'(res_y), 16'h00);
    check("rst_busy", 16'(busy), 16'h0);

    // Load/swap/load, then add and subtract: A=3, B=5
    push(4'b1111, 8'h05);
    push(4'b1110, 8'h00);
    push(4'b1111, 8'h03);
    push(4'b0000, 8'h00);
    push(4'b0001, 8'h00);
    get_result("add_3_5", 8'h08);
    get_result("sub_3_5", 8'hFE);
    wait_idle("idle_seq");
    check("seq_A", 16'(ALed), 16'h03);
    check("seq_B", 16'(BLed), 16'h05);

    // Signed compare: A=-3,B=2; then A=2,B=-3; then A=B=7
    push(4'b1111, 8'h02);
    push(4'b1110, 8'h00);
    push(4'b1111, 8'hFD);
    push(4'b0100, 8'h00);
    get_result("cmp_lt", 8'hFF);
    push(4'b1110, 8'h00);
    push(4'b0100, 8'h00);
    get_result("cmp_gt", 8'h01);
    push(4'b1111, 8'h07);
    push(4'b1110, 8'h00);
    push(4'b1111, 8'h07);
    push(4'b0100, 8'h00);
    get_result("cmp_eq", 8'h00);

    // Bitwise ops with A=0x0C, B=0x0A
    push(4'b1111, 8'h0A);
    push(4'b1110, 8'h00);
    push(4'b1111, 8'h0C);
    push(4'b0101, 8'h00); get_result("and",  8'h08);
    push(4'b0110, 8'h00); get_result("or",   8'h0E);
    push(4'b0111, 8'h00); get_result("xor",  8'h06);
    push(4'b1000, 8'h00); get_result("nand", 8'hF7);
    push(4'b1001, 8'h00); get_result("nor",  8'hF1);

    // Back-pressure: stall in RESP, fill FIFO, check order after release
    push(4'b1010, 8'h00);
    for (int i = 0; i < 40 && !res_valid; i++) step();
    check("bp_resp", 16'(res_valid), 16'h1);
    push(4'b0000, 8'h00);
    push(4'b0001, 8'h00);
    push(4'b0101, 8'h00);
    push(4'b0110, 8'h00);
    check("bp_full_count", 16'(fifo_count), 16'h4);
    check("bp_full_ready", 16'(instr_ready), 16'h0);
    instr_op    = 4'b1011;
    instr_data  = 8'h00;
    instr_valid = 1'b1;
    step();
    step();
    check("bp_count_hold", 16'(fifo_count), 16'h4);
    check("bp_res_stable", 16'(res_y), 16'hF9);
    check("bp_valid_hold", 16'(res_valid), 16'h1);
    get_result("bp_xnor", 8'hF9);
    get_result("bp_add",  8'h16);
    get_result("bp_sub",  8'h02);
    get_result("bp_and",  8'h08);
    get_result("bp_or",   8'h0E);
    get_result("bp_not",  8'hF3);
    check("bp_fifth_taken", 16'(instr_valid), 16'h0);
    wait_idle("idle_bp");

    // Wrap-around corners
    push(4'b1111, 8'h80);
    push(4'b1100, 8'h00); get_result("neg_min", 8'h80);
    push(4'b0011, 8'h00); get_result("sar_min", 8'hC0);
    push(4'b1111, 8'h40);
    push(4'b0010, 8'h00); get_result("shl_64",  8'h80);

    // A=4, B=0: latency of a compute op from an empty, idle sequencer
    push(4'b1111, 8'h00);
    push(4'b1110, 8'h00);
    push(4'b1111, 8'h04);
    wait_idle("idle_lat");
    check("lat_B", 16'(BLed), 16'h00);
    push(4'b0000, 8'h00);
    check("lat_t0", 16'(res_valid), 16'h0);
    step();
    check("lat_t1", 16'(res_valid), 16'h0);
    step();
    check("lat_t2", 16'(res_valid), 16'h1);
    check("lat_y", 16'(res_y), 16'h04);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    push(4'b1101, 8'h00);
    push(4'b0000, 8'h00);
    get_result("movy_add", 8'h04);
    wait_idle("idle_movy");
    check("movy_A", 16'(ALed), 16'h04);
    push(4'b1111, 8'h01);
    push(4'b1101, 8'h00);
    wait_idle("idle_movy2");
    check("movy_A_from_Y", 16'(ALed), 16'h04);

    // Reset in RESP with three queued instructions
    push(4'b0000, 8'h00);
    for (int i = 0; i < 40 && !res_valid; i++) step();
    check("rr_resp", 16'(res_valid), 16'h1);
    push(4'b0001, 8'h00);
    push(4'b0101, 8'h00);
    push(4'b1111, 8'h09);
    check("rr_count3", 16'(fifo_count), 16'h3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rr_res_valid", 16'(res_valid), 16'h0);
    check("rr_count", 16'(fifo_count), 16'h0);
    check("rr_A", 16'(ALed), 16'h00);
    check("rr_B", 16'(BLed), 16'h00);
    check("rr_busy", 16'(busy), 16'h0);
    check("rr_ready", 16'(instr_ready), 16'h1);
    step();
    check("rr_stays_idle", 16'(busy), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: instruction FIFO depth in entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  FIFO can accept; equals not-full.
REQ-006 instr_op  input  4  operation selector, team ALU encoding.
REQ-007 instr_data  input  8  signed operand; used only by op 4'b1111.
REQ-008 res_valid  output  1  result beat pending.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 res_y  output  8  signed result of the last compute op.
REQ-011 ALed  output  8  current register A.
REQ-012 BLed  output  8  current register B.
REQ-013 busy  output  1  high when state is not IDLE or the FIFO is non-empty.
REQ-014 fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Function
REQ-015 An instruction {op, data} SHALL be written into the FIFO on a rising edge where instr_valid and instr_ready are both high.
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
REQ-017 IDLE: if the FIFO is non-empty, pop the head into the instruction register and go to EXEC; otherwise stay in IDLE.
REQ-018 EXEC, compute ops 0000-1100: register the ALU output into Y, drive it on res_y, go to RESP.
REQ-019 EXEC, state ops 1101-1111: update A/B (1101 A<=Y; 1110 swap A and B atomically; 1111 A<=data), leave Y unchanged, go to IDLE; no result beat.
REQ-020 RESP: hold res_valid=1 and res_y stable; on the edge where res_ready=1, go to IDLE.
REQ-021 Compute ops: 0000 A+B, 0001 A-B, 0010 A<<<1, 0011 A>>>1 (sign-preserving), 0100 compare (0 if A==B, +1 if A>B, -1 if A<B, signed), 0101 AND, 0110 OR, 0111 XOR, 1000 NAND, 1001 NOR, 1010 XNOR, 1011 NOT A, 1100 -A.
REQ-022 All arithmetic SHALL be 8-bit two's complement, wrapping modulo 256, with no overflow flag (-128 negated = -128).
REQ-023 Latency: with the FIFO empty and the FSM in IDLE, a compute op accepted at edge t SHALL show res_valid=1 after edge t+2.
REQ-024 Throughput: at most one instruction per 2 cycles for state ops, and per 3 cycles for compute ops with res_ready held high.
REQ-025 A push and a pop on the same edge SHALL leave fifo_count unchanged.
REQ-026 Pushes while full SHALL not occur because instr_ready=0; pops SHALL occur only when non-empty.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH.
REQ-028 Instructions SHALL execute strictly in acceptance order.
REQ-029 A and B SHALL change only in EXEC; ALed/BLed SHALL mirror them with no extra latency.
REQ-030 While in RESP with res_ready=0, the FIFO SHALL keep accepting until full, and no further pop SHALL occur.

Reset
REQ-031 On a rising edge with reset=1: A=0, B=0, Y=0, FIFO empty, fifo_count=0, state=IDLE, res_valid=0, instr_ready=1 (same edge).
REQ-032 Reset SHALL take priority over all other activity; a pending instruction or unaccepted result SHALL be discarded.

Structure
REQ-033 A shared package SHALL hold the 4-bit opcode constants, the FSM state enum and the 8-bit signed data type.
REQ-034 One sub-module, alu_core, SHALL be purely combinational (A, B, op -> Y) implementing REQ-021/022; all registers SHALL live in alu_sequencer.

Verification
REQ-035 Push 1111/5, then 1110, then 1111/3, then 0000; then 0001 -> A=3, B=5; results 8, then -2 (8'hFE).
REQ-036 Compare with A=-3, B=2 -> res_y=-1; with A=2, B=-3 -> +1; with A=B=7 -> 0.
REQ-037 Hold res_ready=0 during a compute op and push 5 more instructions (DEPTH=4) -> instr_ready falls at fifo_count=4; res_y stays stable; order is preserved after release.
REQ-038 A=-128: op 1100 -> -128; op 0011 -> -64; op 0010 on A=64 -> -128.
REQ-039 Assert reset in RESP with fifo_count=3 -> next cycle res_valid=0, fifo_count=0, ALed=BLed=0, busy=0.
REQ-040 Op 0000 with A=4, B=0 gives Y=4; then op 1101, then 0000 -> ALed=4, res_y=4; latency check per REQ-023.
